maxnet_feeder: RTL and testbench
================================

Name: maxnet_feeder

Overview:
- Upstream front-end for the Maxnet winner-take-all core.
- Accepts a stream of IEEE-754 float32 candidates over a valid/ready handshake and buffers four of them, sanitising each into Maxnet's legal (non-negative, finite) domain.
- Drives the Maxnet operand bus a0..a3 and issues a one-cycle start pulse.
- Waits for completion, then returns the Maxnet Result on a valid/ready output with status flags.

Parameters:
- WIDTH, 32: operand/result width; float32 only.
- TIMEOUT, 1024: max cycles waited for mx_done before aborting the batch.
- TW, 11: timer width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_data  in  WIDTH  candidate float32
- in_valid  in  1  in_data valid
- in_ready  out  1  feeder can accept a candidate
- mx_a0, mx_a1, mx_a2, mx_a3  out  WIDTH each  sanitised operands to Maxnet a0..a3
- mx_start  out  1  one-cycle start pulse to Maxnet
- mx_done  in  1  Maxnet completion pulse
- mx_result  in  WIDTH  Maxnet Result, valid when mx_done=1
- res_data  out  WIDTH  captured result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_timeout  out  1  batch aborted by timeout; res_data=0
- res_clamped  out  1  at least one of the 4 inputs was sanitised
- busy  out  1  high in FIRE/WAIT/OUT

Behaviour:
- Single clock domain; all state updates on the rising edge of clk.
- Reset (rst=1, sampled synchronously):
  - state<=LOAD, cnt<=0, timer<=0.
  - mx_a0..mx_a3<=0, mx_start<=0, res_data<=0, res_valid<=0, res_timeout<=0, res_clamped<=0.
  - in_ready=0 while rst=1.
- Reset mid-operation (any state) abandons the batch: partial slots are cleared and no start pulse or result is issued for it.
- States: LOAD -> FIRE -> WAIT -> OUT -> LOAD.
- LOAD:
  - in_ready=1.
  - Accept occurs on in_valid&&in_ready; the sanitised word is written to slot cnt (0..3) and cnt increments.
  - The clamp flag ORs into a per-batch sticky; the sticky is cleared on acceptance of the first word (cnt=0).
  - The accept that takes cnt from 3 wraps cnt to 0 and moves the state to FIRE.
- FIRE:
  - in_ready=0, mx_start=1 for exactly one cycle.
  - mx_a0..mx_a3 are stable from this cycle until the next batch's first accept.
  - Next state is WAIT with timer=0.
- WAIT:
  - timer increments each cycle.
  - mx_done=1: res_data<=mx_result, res_timeout<=0, res_clamped<=sticky, state->OUT.
  - Otherwise, if timer==TIMEOUT-1: res_data<=0, res_timeout<=1, res_clamped<=sticky, state->OUT.
  - If mx_done and expiry occur in the same cycle, mx_done wins (res_timeout=0).
- mx_done outside WAIT (including the FIRE cycle) is ignored.
- OUT:
  - res_valid=1; res_data and the flags are held stable until res_ready=1.
  - On the handshake cycle: res_valid<=0 next cycle, state->LOAD.
  - No input is accepted while in OUT; there is no overlap of batches.
- Latency: 4th accept at edge T gives mx_start high in cycle T+1; earliest res_valid is T+3 (mx_done in the first WAIT cycle).
- Sanitise rules, in priority order (e = bits[30:23], m = bits[22:0]):
  - NaN (e=FF, m!=0): 32'h00000000, clamped.
  - Sign bit set (incl. -0, -Inf): 32'h00000000, clamped; -0 is not flagged.
  - +Inf (32'h7F800000): 32'h7F7FFFFF, clamped.
  - Denormal (e=0, m!=0): 32'h00000000, clamped.
  - Otherwise the word passes unchanged.

Test Plan:
- Plain batch:
  - Stimulus: 0x41500000 (13.0), 0x40B00000 (5.5), 0x42C80000 (100.0), 0x40800000 (4.0) sent back-to-back; model asserts mx_done 5 cycles after mx_start with mx_result=0x42C80000.
  - Required: mx_start is a single-cycle pulse one cycle after the 4th accept; mx_a0..3 equal the inputs; res_data=0x42C80000, res_timeout=0, res_clamped=0.
- Sanitising:
  - Stimulus: 0xC0A00000 (-5.0), 0x7FC00000 (NaN), 0x7F800000 (+Inf), 0x00000001 (denormal).
  - Required: mx_a0..3 = 0x0, 0x0, 0x7F7FFFFF, 0x0; res_clamped=1 on the result.
- Timeout:
  - Stimulus: TIMEOUT=16, mx_done never asserted.
  - Required: res_valid rises 16 cycles after entering WAIT; res_data=0, res_timeout=1.
  - Also: mx_done asserted on the expiry cycle gives res_timeout=0 with the captured result.
- Backpressure:
  - Stimulus: res_ready held 0 for 20 cycles; in_valid held 1 throughout.
  - Required: res_* stable for all 20 cycles; in_ready=0 throughout; next batch is accepted only after the res handshake.
- Gapped input and stray done:
  - Stimulus: in_valid toggled 1-0-1 between words; mx_done pulsed during LOAD and during FIRE.
  - Required: only valid&&ready beats are counted; stray mx_done pulses have no effect.
- Reset mid-operation:
  - Stimulus: rst for 1 cycle after 2 accepts; separately, rst during WAIT.
  - Required: all outputs return to 0; no mx_start or res_valid is issued for the aborted batch; a following full batch of 4 completes normally.

Source files
------------

// File: rtl/maxnet_feeder.sv
// Front-end for the Maxnet winner-take-all core: buffers four sanitised float32
// candidates, fires Maxnet, waits (bounded) for completion and returns the result.
module maxnet_feeder #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] mx_a0,
    output logic [WIDTH-1:0] mx_a1,
    output logic [WIDTH-1:0] mx_a2,
    output logic [WIDTH-1:0] mx_a3,
    output logic             mx_start,
    input  logic             mx_done,
    input  logic [WIDTH-1:0] mx_result,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_timeout,
    output logic             res_clamped,
    output logic             busy
);

    typedef enum logic [1:0] {
        LOAD,
        FIRE,
        WAIT,
        OUT
    } state_t;

    localparam logic [TW-1:0]    TimerOne  = TW'(1);
    localparam logic [TW-1:0]    TimerLast = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] MaxFinite = WIDTH'(32'h7F7FFFFF);

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] slot_q [4];
    logic [WIDTH-1:0] slot_d [4];
    logic [WIDTH-1:0] resData_q, resData_d;
    logic             resTimeout_q, resTimeout_d;
    logic             resClamped_q, resClamped_d;

    logic [7:0]       inExp;
    logic [22:0]      inMan;
    logic [WIDTH-1:0] sanWord;
    logic             sanClamp;

    assign inExp = in_data[30:23];
    assign inMan = in_data[22:0];

    // Map the candidate into Maxnet's legal domain; -0 becomes +0 silently.
    always_comb begin
        sanWord  = in_data;
        sanClamp = 1'b0;
        if (inExp == 8'hFF && inMan != 23'd0) begin
            sanWord  = '0;
            sanClamp = 1'b1;
        end else if (in_data[31]) begin
            sanWord  = '0;
            sanClamp = (in_data[30:0] != 31'd0);
        end else if (inExp == 8'hFF) begin
            sanWord  = MaxFinite;
            sanClamp = 1'b1;
        end else if (inExp == 8'h00 && inMan != 23'd0) begin
            sanWord  = '0;
            sanClamp = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        sticky_d     = sticky_q;
        slot_d       = slot_q;
        resData_d    = resData_q;
        resTimeout_d = resTimeout_q;
        resClamped_d = resClamped_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    slot_d[cnt_q] = sanWord;
                    sticky_d      = (cnt_q == 2'd0) ? sanClamp : (sticky_q | sanClamp);
                    cnt_d         = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = FIRE;
                    end
                end
            end
            FIRE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TimerOne;
                // A completion arriving on the expiry cycle still counts as success.
                if (mx_done) begin
                    resData_d    = mx_result;
                    resTimeout_d = 1'b0;
                    resClamped_d = sticky_q;
                    state_d      = OUT;
                end else if (timer_q == TimerLast) begin
                    resData_d    = '0;
                    resTimeout_d = 1'b1;
                    resClamped_d = sticky_q;
                    state_d      = OUT;
                end
            end
            OUT: begin
                if (res_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            cnt_q        <= 2'd0;
            timer_q      <= '0;
            sticky_q     <= 1'b0;
            slot_q[0]    <= '0;
            slot_q[1]    <= '0;
            slot_q[2]    <= '0;
            slot_q[3]    <= '0;
            resData_q    <= '0;
            resTimeout_q <= 1'b0;
            resClamped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            sticky_q     <= sticky_d;
            slot_q       <= slot_d;
            resData_q    <= resData_d;
            resTimeout_q <= resTimeout_d;
            resClamped_q <= resClamped_d;
        end
    end

    assign in_ready    = (state_q == LOAD) && !rst;
    assign mx_start    = (state_q == FIRE);
    assign res_valid   = (state_q == OUT);
    assign busy        = (state_q != LOAD);
    assign mx_a0       = slot_q[0];
    assign mx_a1       = slot_q[1];
    assign mx_a2       = slot_q[2];
    assign mx_a3       = slot_q[3];
    assign res_data    = resData_q;
    assign res_timeout = resTimeout_q;
    assign res_clamped = resClamped_q;

endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed bench for maxnet_feeder: table of batches plus hand-written corner
// sequences (timeout, backpressure, gapped input, stray done, mid-batch reset).
module tb_maxnet_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mx_a0, mx_a1, mx_a2, mx_a3;
    logic        mx_start;
    logic        mx_done;
    logic [31:0] mx_result;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        res_timeout;
    logic        res_clamped;
    logic        busy;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [3:0][31:0] word;
        logic [3:0][31:0] expOp;
        logic             expClamp;
        logic [31:0]      result;
        logic [7:0]       waitCycles;
    } vec_t;

    vec_t vecs [5];

    maxnet_feeder #(.WIDTH(32), .TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mx_a0(mx_a0), .mx_a1(mx_a1), .mx_a2(mx_a2), .mx_a3(mx_a3),
        .mx_start(mx_start), .mx_done(mx_done), .mx_result(mx_result),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_timeout(res_timeout), .res_clamped(res_clamped), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3, e0, e1, e2, e3,
                                input logic c, input logic [31:0] r, input logic [7:0] k);
        vec_t v;
        v.word[0] = w0; v.word[1] = w1; v.word[2] = w2; v.word[3] = w3;
        v.expOp[0] = e0; v.expOp[1] = e1; v.expOp[2] = e2; v.expOp[3] = e3;
        v.expClamp = c;
        v.result = r;
        v.waitCycles = k;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Sends the four words of a batch; returns in the cycle after the 4th accept.
    task automatic applyStimulus(input vec_t v, input bit gapped, input bit strayDone, input bit holdValid);
        int early = 0;
        for (int i = 0; i < 4; i++) begin
            int guard = 0;
            in_data  = v.word[i];
            in_valid = 1'b1;
            while (!in_ready && guard < 50) begin
                step();
                guard++;
            end
            if (guard >= 50) checkOutput("in_ready wait", 32'(in_ready), 32'd1);
            if (mx_start) early++;
            step();
            if (gapped && i < 3) begin
                in_valid  = 1'b0;
                in_data   = 32'hDEADBEEF;
                mx_done   = strayDone;
                mx_result = 32'hBAD00001;
                if (mx_start) early++;
                step();
                mx_done = 1'b0;
            end
        end
        if (!holdValid) in_valid = 1'b0;
        checkOutput("premature mx_start", 32'(early), 32'd0);
    endtask

    task automatic checkFire(input vec_t v, input bit strayDone);
        checkOutput("mx_start pulse", 32'(mx_start), 32'd1);
        checkOutput("busy in FIRE", 32'(busy), 32'd1);
        checkOutput("mx_a0", mx_a0, v.expOp[0]);
        checkOutput("mx_a1", mx_a1, v.expOp[1]);
        checkOutput("mx_a2", mx_a2, v.expOp[2]);
        checkOutput("mx_a3", mx_a3, v.expOp[3]);
        mx_done   = strayDone;
        mx_result = 32'hBAD00002;
        step();
        mx_done = 1'b0;
        checkOutput("mx_start single cycle", 32'(mx_start), 32'd0);
    endtask

    task automatic finishBatch(input logic [7:0] k, input logic [31:0] result,
                               input logic [31:0] expData, input logic expTo, input logic expCl);
        int early = 0;
        for (int c = 0; c < int'(k); c++) begin
            if (res_valid) early++;
            step();
        end
        checkOutput("res_valid before done", 32'(early), 32'd0);
        mx_done   = 1'b1;
        mx_result = result;
        step();
        mx_done   = 1'b0;
        mx_result = 32'h12345678;
        checkOutput("res_valid", 32'(res_valid), 32'd1);
        checkOutput("res_data", res_data, expData);
        checkOutput("res_timeout", 32'(res_timeout), 32'(expTo));
        checkOutput("res_clamped", 32'(res_clamped), 32'(expCl));
    endtask

    task automatic doHandshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checkOutput("res_valid after handshake", 32'(res_valid), 32'd0);
        checkOutput("in_ready after handshake", 32'(in_ready), 32'd1);
        checkOutput("busy after handshake", 32'(busy), 32'd0);
    endtask

    task automatic runBatch(input vec_t v);
        applyStimulus(v, 1'b0, 1'b0, 1'b0);
        checkFire(v, 1'b0);
        finishBatch(v.waitCycles, v.result, v.result, 1'b0, v.expClamp);
        doHandshake();
    endtask

    initial begin
        int bad;
        vecs[0] = mk(32'h41500000, 32'h40B00000, 32'h42C80000, 32'h40800000,
                     32'h41500000, 32'h40B00000, 32'h42C80000, 32'h40800000, 1'b0, 32'h42C80000, 8'd4);
        vecs[1] = mk(32'hC0A00000, 32'h7FC00000, 32'h7F800000, 32'h00000001,
                     32'h00000000, 32'h00000000, 32'h7F7FFFFF, 32'h00000000, 1'b1, 32'h7F7FFFFF, 8'd0);
        vecs[2] = mk(32'h80000000, 32'h00000000, 32'h3F800000, 32'h7F7FFFFF,
                     32'h00000000, 32'h00000000, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 32'h3F800000, 8'd2);
        vecs[3] = mk(32'h3F800000, 32'hFF800000, 32'h40000000, 32'h007FFFFF,
                     32'h3F800000, 32'h00000000, 32'h40000000, 32'h00000000, 1'b1, 32'h40000000, 8'd1);
        vecs[4] = mk(32'h00800000, 32'h7F800001, 32'hFFC00000, 32'h7F7FFFFF,
                     32'h00800000, 32'h00000000, 32'h00000000, 32'h7F7FFFFF, 1'b1, 32'h7F7FFFFF, 8'd3);

        rst = 1'b1; in_data = '0; in_valid = 1'b0; mx_done = 1'b0; mx_result = '0; res_ready = 1'b0;
        step();
        step();
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset mx_a0", mx_a0, 32'd0);
        checkOutput("reset mx_a3", mx_a3, 32'd0);
        checkOutput("reset mx_start", 32'(mx_start), 32'd0);
        checkOutput("reset res_valid", 32'(res_valid), 32'd0);
        checkOutput("reset res_data", res_data, 32'd0);
        checkOutput("reset flags", {30'd0, res_timeout, res_clamped}, 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", 32'(in_ready), 32'd1);

        $display("[TB] table-driven batches");
        for (int i = 0; i < 5; i++) begin
            runBatch(vecs[i]);
        end

        $display("[TB] timeout with no done");
        applyStimulus(vecs[3], 1'b0, 1'b0, 1'b0);
        checkFire(vecs[3], 1'b0);
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            if (res_valid) bad++;
            step();
        end
        checkOutput("timeout early res_valid", 32'(bad), 32'd0);
        checkOutput("timeout res_valid", 32'(res_valid), 32'd1);
        checkOutput("timeout res_data", res_data, 32'd0);
        checkOutput("timeout res_timeout", 32'(res_timeout), 32'd1);
        checkOutput("timeout res_clamped", 32'(res_clamped), 32'd1);
        doHandshake();

        $display("[TB] done on expiry cycle");
        applyStimulus(vecs[0], 1'b0, 1'b0, 1'b0);
        checkFire(vecs[0], 1'b0);
        finishBatch(8'd15, 32'h41200000, 32'h41200000, 1'b0, 1'b0);
        doHandshake();

        $display("[TB] backpressure");
        applyStimulus(vecs[1], 1'b0, 1'b0, 1'b1);
        checkFire(vecs[1], 1'b0);
        in_data = vecs[3].word[0];
        finishBatch(8'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (res_valid !== 1'b1 || res_data !== 32'h7F7FFFFF || res_timeout !== 1'b0 ||
                res_clamped !== 1'b1 || in_ready !== 1'b0 || mx_a0 !== 32'd0) bad++;
            step();
        end
        checkOutput("backpressure stability", 32'(bad), 32'd0);
        doHandshake();
        checkOutput("no accept during OUT", mx_a0, 32'd0);
        applyStimulus(vecs[3], 1'b0, 1'b0, 1'b0);
        checkFire(vecs[3], 1'b0);
        finishBatch(vecs[3].waitCycles, vecs[3].result, vecs[3].result, 1'b0, 1'b1);
        doHandshake();

        $display("[TB] gapped input with stray done");
        applyStimulus(vecs[0], 1'b1, 1'b1, 1'b0);
        checkFire(vecs[0], 1'b1);
        finishBatch(vecs[0].waitCycles, 32'h42C80000, 32'h42C80000, 1'b0, 1'b0);
        doHandshake();

        $display("[TB] reset after two accepts");
        in_valid = 1'b1;
        in_data  = 32'h41000000;
        step();
        in_data  = 32'h41100000;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("in_ready during rst", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("partial slot0 cleared", mx_a0, 32'd0);
        checkOutput("partial slot1 cleared", mx_a1, 32'd0);
        checkOutput("no start after reset", 32'(mx_start), 32'd0);
        checkOutput("busy after reset", 32'(busy), 32'd0);
        runBatch(vecs[2]);

        $display("[TB] reset during WAIT");
        applyStimulus(vecs[4], 1'b0, 1'b0, 1'b0);
        checkFire(vecs[4], 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkOutput("wait-reset slots", mx_a0 | mx_a1 | mx_a2 | mx_a3, 32'd0);
        checkOutput("wait-reset busy", 32'(busy), 32'd0);
        mx_done   = 1'b1;
        mx_result = 32'h40400000;
        step();
        mx_done = 1'b0;
        checkOutput("wait-reset no res_valid", 32'(res_valid), 32'd0);
        checkOutput("wait-reset res_data", res_data, 32'd0);
        checkOutput("wait-reset in_ready", 32'(in_ready), 32'd1);
        runBatch(vecs[4]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
